// File: rtl/memory_xlen.sv
// Byte-addressed memory model for the core bench: registered fetch and load ports,
// byte-strobe stores, alignment/range exceptions and an LR/SC reservation tracker.
module memory_xlen #(
    parameter  int              XLEN       = 32,
    parameter  int              SIZE       = 20,
    parameter  logic [XLEN-1:0] START_ADDR = XLEN'(32'h8000_0000),
    localparam int              WB         = XLEN / 8
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            in_fetch_valid,
    input  logic [XLEN-1:0] in_fetch_address,
    output logic            out_fetch_valid,
    output logic [XLEN-1:0] out_fetch_data,
    output logic            out_fetch_exception,
    input  logic            in_read_valid,
    input  logic            in_read_reserve,
    input  logic [XLEN-1:0] in_read_address,
    output logic            out_read_valid,
    output logic [XLEN-1:0] out_read_data,
    output logic            out_read_exception,
    input  logic            in_write_enable,
    input  logic            in_write_conditional,
    input  logic [XLEN-1:0] in_write_address,
    input  logic [XLEN-1:0] in_write_data,
    input  logic [WB-1:0]   in_write_strobe,
    output logic            out_write_exception,
    output logic            out_reservation,
    output logic            out_write_done
);

    localparam int OB = $clog2(WB);

    logic [7:0] mem [2**SIZE];

    logic [XLEN-1:0] fetch_off, read_off, write_off;
    logic            fetch_exc, read_exc, write_exc;
    logic            res_valid;
    logic [SIZE-1:0] res_addr;
    logic            sc_ok, do_write;

    function automatic logic is_exc(input logic [XLEN-1:0] off);
        return ((off >> SIZE) != '0) || (off[OB-1:0] != '0);
    endfunction

    function automatic logic [XLEN-1:0] rd_word(input logic [SIZE-1:0] idx);
        logic [XLEN-1:0] w;
        w = '0;
        for (int i = 0; i < WB; i++) w[8*i +: 8] = mem[idx + SIZE'(i)];
        return w;
    endfunction

    // Offsets wrap modulo 2^XLEN, so addresses below START_ADDR land far out of range.
    assign fetch_off = in_fetch_address - START_ADDR;
    assign read_off  = in_read_address  - START_ADDR;
    assign write_off = in_write_address - START_ADDR;
    assign fetch_exc = is_exc(fetch_off);
    assign read_exc  = is_exc(read_off);
    assign write_exc = is_exc(write_off);

    assign sc_ok    = res_valid && (res_addr == write_off[SIZE-1:0]) && !write_exc;
    assign do_write = RESET_N && in_write_enable && !write_exc && (!in_write_conditional || sc_ok);

    // NOTE: the storage array has no reset; contents must survive RESET_N, and
    // clearing a large array on reset would also defeat RAM inference.
    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int i = 0; i < WB; i++) begin
                if (in_write_strobe[i]) mem[write_off[SIZE-1:0] + SIZE'(i)] <= in_write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            out_fetch_valid     <= 1'b0;
            out_fetch_data      <= '0;
            out_fetch_exception <= 1'b0;
            out_read_valid      <= 1'b0;
            out_read_data       <= '0;
            out_read_exception  <= 1'b0;
            out_write_exception <= 1'b0;
            out_reservation     <= 1'b0;
            out_write_done      <= 1'b0;
            res_valid           <= 1'b0;
            res_addr            <= '0;
        end else begin
            out_fetch_valid     <= in_fetch_valid;
            out_fetch_exception <= in_fetch_valid && fetch_exc;
            out_fetch_data      <= (in_fetch_valid && !fetch_exc) ? rd_word(fetch_off[SIZE-1:0]) : '0;
            out_read_valid      <= in_read_valid;
            out_read_exception  <= in_read_valid && read_exc;
            out_read_data       <= (in_read_valid && !read_exc) ? rd_word(read_off[SIZE-1:0]) : '0;
            out_write_done      <= in_write_enable;
            out_write_exception <= in_write_enable && write_exc;
            out_reservation     <= in_write_enable && (!in_write_conditional || sc_ok);

            if (in_write_enable) begin
                if (in_write_conditional) res_valid <= 1'b0;
                else if (!write_exc && (write_off[SIZE-1:0] == res_addr)) res_valid <= 1'b0;
            end
            // A same-cycle LR is ordered after the store, so it always wins the tracker.
            if (in_read_valid && in_read_reserve && !read_exc) begin
                res_valid <= 1'b1;
                res_addr  <= read_off[SIZE-1:0];
            end
        end
    end

endmodule

// File: tb/tb_memory_xlen.sv
// Bench for memory_xlen (XLEN=64, SIZE=20): directed plan steps followed by random
// traffic checked against a byte-level reference model of the memory and reservation.
module tb_memory_xlen;

    localparam int          XLEN = 64;
    localparam int          SIZE = 20;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          WIN  = 1024;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        in_fetch_valid = 1'b0;
    logic [63:0] in_fetch_address = '0;
    logic        out_fetch_valid;
    logic [63:0] out_fetch_data;
    logic        out_fetch_exception;
    logic        in_read_valid = 1'b0;
    logic        in_read_reserve = 1'b0;
    logic [63:0] in_read_address = '0;
    logic        out_read_valid;
    logic [63:0] out_read_data;
    logic        out_read_exception;
    logic        in_write_enable = 1'b0;
    logic        in_write_conditional = 1'b0;
    logic [63:0] in_write_address = '0;
    logic [63:0] in_write_data = '0;
    logic [7:0]  in_write_strobe = '0;
    logic        out_write_exception;
    logic        out_reservation;
    logic        out_write_done;

    memory_xlen #(.XLEN(XLEN), .SIZE(SIZE)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .in_fetch_valid(in_fetch_valid), .in_fetch_address(in_fetch_address),
        .out_fetch_valid(out_fetch_valid), .out_fetch_data(out_fetch_data),
        .out_fetch_exception(out_fetch_exception),
        .in_read_valid(in_read_valid), .in_read_reserve(in_read_reserve),
        .in_read_address(in_read_address), .out_read_valid(out_read_valid),
        .out_read_data(out_read_data), .out_read_exception(out_read_exception),
        .in_write_enable(in_write_enable), .in_write_conditional(in_write_conditional),
        .in_write_address(in_write_address), .in_write_data(in_write_data),
        .in_write_strobe(in_write_strobe), .out_write_exception(out_write_exception),
        .out_reservation(out_reservation), .out_write_done(out_write_done)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_failed = 0;

    // Reference model: window of bytes plus the reservation as plain variables.
    logic [7:0]  mm [WIN];
    bit          res_v = 1'b0;
    logic [63:0] res_a = '0;
    logic        e_fv, e_fe, e_rv, e_re, e_wd, e_we, e_res;
    logic [63:0] e_fd, e_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] off_of(input logic [63:0] a);
        return a - BASE;
    endfunction

    function automatic bit m_exc(input logic [63:0] a);
        logic [63:0] o;
        o = off_of(a);
        return (o >= 64'(2**SIZE)) || (o % 8 != 0);
    endfunction

    function automatic logic [63:0] m_read(input logic [63:0] a);
        logic [63:0] v;
        int o;
        o = int'(off_of(a));
        v = '0;
        for (int i = 7; i >= 0; i--) v = (v << 8) | 64'(mm[o + i]);
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".fetch_valid"}, 64'(out_fetch_valid), 64'(e_fv));
        chk({tag, ".fetch_exc"},   64'(out_fetch_exception), 64'(e_fe));
        chk({tag, ".fetch_data"},  out_fetch_data, e_fd);
        chk({tag, ".read_valid"},  64'(out_read_valid), 64'(e_rv));
        chk({tag, ".read_exc"},    64'(out_read_exception), 64'(e_re));
        chk({tag, ".read_data"},   out_read_data, e_rd);
        chk({tag, ".write_done"},  64'(out_write_done), 64'(e_wd));
        chk({tag, ".write_exc"},   64'(out_write_exception), 64'(e_we));
        chk({tag, ".reservation"}, 64'(out_reservation), 64'(e_res));
    endtask

    // One clock with any mix of requests; expectations come from the model's pre-cycle state.
    task automatic cyc(input string tag,
                       input logic fv, input logic [63:0] fa,
                       input logic rv, input logic rr, input logic [63:0] ra,
                       input logic we, input logic wc, input logic [63:0] wa,
                       input logic [63:0] wd, input logic [7:0] ws);
        bit sc_ok;
        in_fetch_valid = fv; in_fetch_address = fa;
        in_read_valid = rv; in_read_reserve = rr; in_read_address = ra;
        in_write_enable = we; in_write_conditional = wc; in_write_address = wa;
        in_write_data = wd; in_write_strobe = ws;

        e_fv = fv; e_fe = fv && m_exc(fa); e_fd = (fv && !m_exc(fa)) ? m_read(fa) : '0;
        e_rv = rv; e_re = rv && m_exc(ra); e_rd = (rv && !m_exc(ra)) ? m_read(ra) : '0;
        e_wd = we; e_we = we && m_exc(wa);
        sc_ok = res_v && (res_a == off_of(wa)) && !m_exc(wa);
        e_res = we && (!wc || sc_ok);
        if (we && !m_exc(wa) && (!wc || sc_ok))
            for (int i = 0; i < 8; i++) if (ws[i]) mm[int'(off_of(wa)) + i] = wd[8*i +: 8];
        if (we && (wc || (!m_exc(wa) && off_of(wa) == res_a))) res_v = 1'b0;
        if (rv && rr && !m_exc(ra)) begin res_v = 1'b1; res_a = off_of(ra); end

        tick();
        in_fetch_valid = 1'b0; in_read_valid = 1'b0; in_read_reserve = 1'b0;
        in_write_enable = 1'b0; in_write_conditional = 1'b0;
        check_outputs(tag);
    endtask

    task automatic rd(input string tag, input logic [63:0] a);
        cyc(tag, 0, '0, 1, 0, a, 0, 0, '0, '0, '0);
    endtask

    task automatic lr(input string tag, input logic [63:0] a);
        cyc(tag, 0, '0, 1, 1, a, 0, 0, '0, '0, '0);
    endtask

    task automatic wr(input string tag, input logic cond, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] s);
        cyc(tag, 0, '0, 0, 0, '0, 1, cond, a, d, s);
    endtask

    function automatic logic [63:0] rand_addr(input bit allow_misaligned);
        int r;
        logic [63:0] w;
        r = int'($urandom_range(0, 99));
        w = 64'($urandom_range(0, 15)) * 8;
        if (allow_misaligned && r < 10) return BASE + w + 64'($urandom_range(1, 7));
        if (r < 14) return 64'h8010_0000 + w;
        if (r < 17) return 64'h7FFF_FFF8;
        if (r < 30) return BASE + 64'($urandom_range(0, WIN / 8 - 1)) * 8;
        return BASE + w;
    endfunction

    initial begin
        logic [63:0] d;

        // Reset state
        e_fv = 0; e_fe = 0; e_fd = '0; e_rv = 0; e_re = 0; e_rd = '0;
        e_wd = 0; e_we = 0; e_res = 0;
        tick(); tick();
        check_outputs("reset");
        RESET_N = 1'b1;

        // Preload the model window through the store port
        for (int w = 0; w < WIN / 8; w++) begin
            d = {$urandom, $urandom};
            if (w == 2) d = 64'h0807_0605_0403_0201;
            if (w == 4) d = 64'h0000_0000_1122_3344;
            wr("preload", 0, BASE + 64'(w * 8), d, 8'hFF);
        end

        rd("load_0x10", 64'h8000_0010);
        chk("load_0x10.const", out_read_data, 64'h0807_0605_0403_0201);

        wr("strobe_wr", 0, 64'h8000_0020, 64'h0000_0000_AABB_CCDD, 8'b0000_0101);
        rd("strobe_rd", 64'h8000_0020);
        chk("strobe_rd.const", out_read_data, 64'h0000_0000_11BB_33DD);

        rd("misaligned_rd", 64'h8000_0002);
        chk("misaligned_rd.exc", 64'(out_read_exception), 64'd1);
        wr("range_wr", 0, 64'h8010_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        chk("range_wr.exc", 64'(out_write_exception), 64'd1);
        cyc("below_base_fetch", 1, 64'h7FFF_FFF8, 0, 0, '0, 0, 0, '0, '0, '0);

        // LR/SC
        lr("lr1", 64'h8000_0040);
        wr("sc1", 1, 64'h8000_0040, 64'h1111_2222_3333_4444, 8'hFF);
        chk("sc1.ok", 64'(out_reservation), 64'd1);
        rd("sc1_rd", 64'h8000_0040);
        wr("sc2", 1, 64'h8000_0040, 64'h5555_6666_7777_8888, 8'hFF);
        chk("sc2.fail", 64'(out_reservation), 64'd0);
        rd("sc2_rd", 64'h8000_0040);
        lr("lr3", 64'h8000_0040);
        wr("plain3", 0, 64'h8000_0040, 64'h0123_4567_89AB_CDEF, 8'hF0);
        wr("sc3", 1, 64'h8000_0040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        chk("sc3.fail", 64'(out_reservation), 64'd0);
        lr("lr4", 64'h8000_0048);
        wr("plain4_other", 0, 64'h8000_0050, 64'h0A0A_0A0A_0A0A_0A0A, 8'hFF);
        wr("sc4", 1, 64'h8000_0048, 64'h4848_4848_4848_4848, 8'hFF);
        chk("sc4.ok", 64'(out_reservation), 64'd1);

        // Same-cycle LR and SC, then LR plus plain store to the reserved word
        lr("lr5", 64'h8000_0058);
        cyc("lr_sc_same", 0, '0, 1, 1, 64'h8000_0060, 1, 1, 64'h8000_0058, 64'h5858, 8'hFF);
        wr("sc_after_pair", 1, 64'h8000_0060, 64'h6060, 8'hFF);
        chk("sc_after_pair.ok", 64'(out_reservation), 64'd1);
        lr("lr6", 64'h8000_0068);
        cyc("lr_st_same", 0, '0, 1, 1, 64'h8000_0068, 1, 0, 64'h8000_0068, 64'h6868, 8'hFF);
        wr("sc6", 1, 64'h8000_0068, 64'h6969, 8'hFF);
        chk("sc6.ok", 64'(out_reservation), 64'd1);

        // Read-before-write collision, then back-to-back fetches
        cyc("collide", 0, '0, 1, 0, 64'h8000_0070, 1, 0, 64'h8000_0070, 64'hC0C0_C0C0_C0C0_C0C0, 8'hFF);
        rd("collide_after", 64'h8000_0070);
        for (int i = 0; i < 4; i++)
            cyc("fetch_b2b", 1, BASE + 64'(i * 8), 0, 0, '0, 0, 0, '0, '0, '0);

        // Reset mid-stream: LR at 0x50, a load accepted, then reset with an ignored store
        lr("lr7", 64'h8000_0050);
        rd("pre_reset_rd", 64'h8000_0050);
        RESET_N = 1'b0;
        in_write_enable = 1'b1; in_write_address = 64'h8000_0050;
        in_write_data = 64'hBAD0_BAD0_BAD0_BAD0; in_write_strobe = 8'hFF;
        res_v = 1'b0;
        e_fv = 0; e_fe = 0; e_fd = '0; e_rv = 0; e_re = 0; e_rd = '0;
        e_wd = 0; e_we = 0; e_res = 0;
        tick();
        in_write_enable = 1'b0;
        check_outputs("mid_reset");
        RESET_N = 1'b1;
        wr("sc_after_reset", 1, 64'h8000_0050, 64'h7777, 8'hFF);
        chk("sc_after_reset.fail", 64'(out_reservation), 64'd0);
        rd("retained", 64'h8000_0050);
        chk("retained.const", out_read_data, 64'h0A0A_0A0A_0A0A_0A0A);

        // Random concurrent traffic
        for (int n = 0; n < 400; n++) begin
            logic fv, rv, rr, we, wc;
            fv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) == 0);
            we = 1'($urandom_range(0, 1));
            wc = ($urandom_range(0, 2) == 0);
            cyc("random", fv, rand_addr(1), rv, rr, rand_addr(1), we, wc, rand_addr(0),
                {$urandom, $urandom}, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
